// File: rtl/seq_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble), one operand bit per clock.
// Produces four registered BCD digits for the seven-segment display scanner.
module seq_bcd_converter #(
   parameter int BIN_W = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [3:0]       thousands,
   output logic [3:0]       hundreds,
   output logic [3:0]       tens,
   output logic [3:0]       ones
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [15:0]      scratch_q, scratch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      digits_q, digits_d;
   logic             done_q, done_d;

   logic [15:0]      adj;
   logic [15:0]      shifted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         digits_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         digits_q  <= digits_d;
         done_q    <= done_d;
      end
   end

   // Add-3 correction on every nibble that would exceed 9 after doubling.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < 4; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
      shifted = (adj << 1) | {15'd0, bin_q[BIN_W-1]};
   end

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      digits_d  = digits_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d     = bin;
               scratch_d = '0;
               cnt_d     = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = shifted;
            bin_d     = bin_q << 1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               digits_d = shifted;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q == SHIFT);
   assign done      = done_q;
   assign thousands = digits_q[15:12];
   assign hundreds  = digits_q[11:8];
   assign tens      = digits_q[7:4];
   assign ones      = digits_q[3:0];

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Self-checking bench for seq_bcd_converter: directed scenarios plus a random
// sweep checked against a decimal (divide/modulo) reference model.
module tb_seq_bcd_converter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [12:0] bin;
   logic        busy;
   logic        done;
   logic [3:0]  thousands, hundreds, tens, ones;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [15:0] prev_digits;

   seq_bcd_converter #(.BIN_W(13)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bin       (bin),
      .busy      (busy),
      .done      (done),
      .thousands (thousands),
      .hundreds  (hundreds),
      .tens      (tens),
      .ones      (ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_bcd(input int unsigned v);
      ref_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [15:0] digits();
      digits = {thousands, hundreds, tens, ones};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One conversion: busy high after edges N..N+12, done after N+13, digits frozen meanwhile.
   task automatic convert(input logic [12:0] v, input string tag);
      @(negedge clk);
      start = 1'b1;
      bin   = v;
      @(posedge clk); #1;
      start = 1'b0;
      bin   = 13'($urandom);
      check({tag, "_acc"}, {14'd0, busy, done, digits()}, {14'd0, 1'b1, 1'b0, prev_digits});
      for (int i = 1; i < 13; i++) begin
         @(posedge clk); #1;
         if (i == 5) begin
            start = 1'b1;
            bin   = 13'($urandom);
         end else begin
            start = 1'b0;
         end
         check({tag, "_shift"}, {14'd0, busy, done, digits()}, {14'd0, 1'b1, 1'b0, prev_digits});
      end
      start = 1'b0;
      @(posedge clk); #1;
      check({tag, "_done"}, {14'd0, busy, done, digits()}, {14'd0, 1'b0, 1'b1, ref_bcd(v)});
      prev_digits = ref_bcd(v);
   endtask

   initial begin
      int ndone;
      int done_at[$];
      logic [15:0] done_val[$];

      rst_n = 1'b0;
      start = 1'b0;
      bin   = '0;
      prev_digits = '0;
      #1;
      check("reset", {14'd0, busy, done, digits()}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      convert(13'd0, "zero");
      convert(13'd1234, "d1234");
      convert(13'd8191, "d8191");

      // Extra starts during busy are ignored, not queued.
      @(negedge clk);
      start = 1'b1;
      bin   = 13'd4095;
      ndone = 0;
      for (int e = 0; e <= 20; e++) begin
         @(posedge clk); #1;
         start = (e == 2 || e == 6);
         if (start) bin = 13'd7;
         if (done) ndone++;
         if (e == 13) check("ign_digits", {16'd0, digits()}, {16'd0, ref_bcd(4095)});
      end
      check("ign_ndone", ndone, 1);
      check("ign_idle", {31'd0, busy}, 32'd0);
      prev_digits = ref_bcd(4095);

      // start held high: back-to-back conversions 14 cycles apart.
      @(negedge clk);
      start = 1'b1;
      bin   = 13'd4095;
      for (int e = 0; e <= 30; e++) begin
         @(posedge clk); #1;
         if (e == 0) bin = 13'd7;
         if (e == 14) start = 1'b0;
         if (done) begin
            done_at.push_back(e);
            done_val.push_back(digits());
         end
      end
      check("b2b_count", done_at.size(), 2);
      if (done_at.size() == 2) begin
         check("b2b_first_at", done_at[0], 13);
         check("b2b_gap", done_at[1] - done_at[0], 14);
         check("b2b_val0", {16'd0, done_val[0]}, {16'd0, ref_bcd(4095)});
         check("b2b_val1", {16'd0, done_val[1]}, {16'd0, ref_bcd(7)});
      end
      prev_digits = ref_bcd(7);

      // Reset mid-conversion aborts with no done pulse.
      @(negedge clk);
      start = 1'b1;
      bin   = 13'd999;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async", {14'd0, busy, done, digits()}, 32'd0);
      ndone = 0;
      for (int e = 0; e < 15; e++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check("rst_quiet", ndone, 0);
      rst_n = 1'b1;
      prev_digits = '0;
      convert(13'd999, "after_rst");

      // Random sweep with random idle gaps (including zero for back-to-back).
      for (int k = 0; k < 1000; k++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            check("idle_hold", {14'd0, busy, done, digits()}, {14'd0, 1'b0, 1'b0, prev_digits});
         end
         convert(13'($urandom_range(0, 8191)), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
